// File: rtl/byte_word_packer.sv
// Byte-to-word packer: collects BYTE_W-bit symbols over a valid/ready handshake
// and presents DATA_W-bit words (full or flushed partials) to a downstream register.
module byte_word_packer #(
    parameter int DATA_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [2:0]        byte_cnt
);

    localparam int NB = DATA_W / BYTE_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] buffer, buf_nxt, packed_buf, word_nxt;
    logic [2:0]        bc_nxt;
    logic [CW:0]       fill;
    logic              accept;
    logic              emit;

    assign in_ready = rst & (state == COLLECT);
    assign accept   = in_valid & in_ready;
    assign fill     = {1'b0, cnt} + (CW+1)'(accept);

    // Buffer contents as they would be after this cycle's byte (if any) lands.
    always_comb begin
        packed_buf = buffer;
        if (accept) begin
            if (LSB_FIRST != 0) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (cnt == CW'(i))
                        packed_buf[i*BYTE_W +: BYTE_W] = in_data;
                end
            end else begin
                packed_buf = (buffer << BYTE_W) | DATA_W'(in_data);
            end
        end
    end

    // A word leaves on the last byte of a lane set, or on flush with anything pending.
    assign emit = (accept && (cnt == CW'(NB-1))) || (flush && (fill != '0));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        buf_nxt   = buffer;
        word_nxt  = word_out;
        bc_nxt    = byte_cnt;
        case (state)
            COLLECT: begin
                if (emit) begin
                    word_nxt  = packed_buf;
                    bc_nxt    = 3'(fill);
                    cnt_nxt   = '0;
                    buf_nxt   = packed_buf;
                    state_nxt = HOLD;
                end else if (accept) begin
                    cnt_nxt = cnt + CW'(1);
                    buf_nxt = packed_buf;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    buf_nxt   = '0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            cnt        <= '0;
            buffer     <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            buffer     <= buf_nxt;
            word_out   <= word_nxt;
            word_valid <= (state_nxt == HOLD);
            byte_cnt   <= bc_nxt;
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: LSB-first and MSB-first instances share stimulus.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;

    logic        ir_l, wv_l, ir_m, wv_m;
    logic [31:0] wo_l, wo_m;
    logic [2:0]  bc_l, bc_m;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    byte_word_packer #(.DATA_W(32), .BYTE_W(8), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_l),
        .flush(flush), .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
        .byte_cnt(bc_l)
    );

    byte_word_packer #(.DATA_W(32), .BYTE_W(8), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_m),
        .flush(flush), .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
        .byte_cnt(bc_m)
    );

    typedef struct {
        logic [31:0] wl;
        logic [31:0] wm;
        int unsigned n;
    } exp_t;

    exp_t        sbq[$];
    exp_t        handq[$];
    logic [7:0]  mq[$];
    logic        model_hold = 1'b0;
    int unsigned nacc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_word(input logic [31:0] wl, input logic [31:0] wm, input int unsigned n);
        exp_t e;
        e.wl = wl; e.wm = wm; e.n = n;
        handq.push_back(e);
    endtask

    // One clock cycle of stimulus; the transaction model decides acceptance and word timing.
    task automatic cyc(input logic v, input logic [7:0] d, input logic fl, input logic wr);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; flush = fl; word_ready = wr;
        #1;
        chk("in_ready_l", {31'd0, ir_l}, {31'd0, !model_hold});
        chk("in_ready_m", {31'd0, ir_m}, {31'd0, !model_hold});
        chk("word_valid_l", {31'd0, wv_l}, {31'd0, model_hold});
        chk("word_valid_m", {31'd0, wv_m}, {31'd0, model_hold});
        if (!model_hold) begin
            if (v) begin
                mq.push_back(d);
                nacc++;
            end
            if (mq.size() == 4 || (fl && mq.size() > 0)) begin
                if (handq.size() > 0) begin
                    e = handq.pop_front();
                end else begin
                    e.wl = '0; e.wm = '0; e.n = mq.size();
                    for (int i = 0; i < mq.size(); i++) begin
                        e.wl = e.wl | (32'(mq[i]) << (8*i));
                        e.wm = (e.wm << 8) | 32'(mq[i]);
                    end
                end
                sbq.push_back(e);
                mq.delete();
                model_hold = 1'b1;
            end
        end else if (wr) begin
            model_hold = 1'b0;
        end
    endtask

    // Monitor: pops one expected word per rising word_valid, checks stability while held.
    initial begin
        logic        pv;
        logic [31:0] hl, hm;
        logic [2:0]  hbl, hbm;
        exp_t        e;
        pv = 1'b0; hl = '0; hm = '0; hbl = '0; hbm = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wv_l && !pv) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("word_out_l", wo_l, e.wl);
                    chk("word_out_m", wo_m, e.wm);
                    chk("byte_cnt_l", {29'd0, bc_l}, 32'(e.n));
                    chk("byte_cnt_m", {29'd0, bc_m}, 32'(e.n));
                end
                hl = wo_l; hm = wo_m; hbl = bc_l; hbm = bc_m;
            end else if (wv_l && pv) begin
                chk("hold_word_l", wo_l, hl);
                chk("hold_word_m", wo_m, hm);
                chk("hold_cnt_l", {29'd0, bc_l}, {29'd0, hbl});
                chk("hold_cnt_m", {29'd0, bc_m}, {29'd0, hbm});
            end
            pv = wv_l;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cycles;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_word_out", wo_l, 32'h0);
        chk("rst_word_valid", {31'd0, wv_l}, 32'd0);
        chk("rst_byte_cnt", {29'd0, bc_l}, 32'd0);
        chk("rst_in_ready", {31'd0, ir_l}, 32'd0);
        rst = 1'b1;

        // Full word, consecutive bytes, word_ready held high
        exp_word(32'h44332211, 32'h11223344, 4);
        cyc(1, 8'h11, 0, 1); cyc(1, 8'h22, 0, 1); cyc(1, 8'h33, 0, 1); cyc(1, 8'h44, 0, 1);
        cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1);

        // Backpressure: bytes offered during HOLD must not be consumed
        exp_word(32'h88776655, 32'h55667788, 4);
        cyc(1, 8'h55, 0, 0); cyc(1, 8'h66, 0, 0); cyc(1, 8'h77, 0, 0); cyc(1, 8'h88, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'h99, 1, 0);
        cyc(0, 8'h00, 0, 1);
        exp_word(32'hA4A3A2A1, 32'hA1A2A3A4, 4);
        cyc(1, 8'hA1, 0, 1); cyc(1, 8'hA2, 0, 1); cyc(1, 8'hA3, 0, 1); cyc(1, 8'hA4, 0, 1);
        cyc(0, 8'h00, 0, 1);

        // Flush A: two bytes then a lone flush
        exp_word(32'h0000BBAA, 32'h0000AABB, 2);
        cyc(1, 8'hAA, 0, 1); cyc(1, 8'hBB, 0, 1); cyc(0, 8'h00, 1, 1); cyc(0, 8'h00, 0, 1);

        // Flush B: nothing pending, no word expected
        cyc(0, 8'h00, 1, 1); cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1);

        // Flush C: flush coincides with the third byte
        exp_word(32'h00CCBBAA, 32'h00AABBCC, 3);
        cyc(1, 8'hAA, 0, 1); cyc(1, 8'hBB, 0, 1); cyc(1, 8'hCC, 1, 1); cyc(0, 8'h00, 0, 1);

        // Reset mid-word, asserted between edges
        cyc(1, 8'hE1, 0, 1); cyc(1, 8'hE2, 0, 1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_word_out_l", wo_l, 32'h0);
        chk("midrst_word_out_m", wo_m, 32'h0);
        chk("midrst_word_valid", {31'd0, wv_l}, 32'd0);
        chk("midrst_byte_cnt", {29'd0, bc_l}, 32'd0);
        chk("midrst_in_ready", {31'd0, ir_l}, 32'd0);
        mq.delete();
        model_hold = 1'b0;
        #1 rst = 1'b1;
        exp_word(32'h04030201, 32'h01020304, 4);
        cyc(1, 8'h01, 0, 1); cyc(1, 8'h02, 0, 1); cyc(1, 8'h03, 0, 1); cyc(1, 8'h04, 0, 1);
        cyc(0, 8'h00, 0, 1);

        // Random stall soak
        nacc = 0;
        cycles = 0;
        while (nacc < 1000 && cycles < 20000) begin
            cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 6);
            cycles++;
        end
        chk("soak_bytes_accepted", nacc, 1000);
        for (int i = 0; i < 20 && (model_hold || mq.size() > 0); i++) cyc(0, 8'h00, 1, 1);
        repeat (3) cyc(0, 8'h00, 0, 1);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
Upstream feeder for the 32-bit enabled holding register. Accepts a byte stream over a valid/ready handshake and packs bytes into DATA_W-bit words. Presents each completed or flushed word with a valid/ready handshake. The downstream register's enable is driven by word_valid & word_ready, and its data input by word_out.

Parameters:
DATA_W, 32, output word width; must be a multiple of BYTE_W.
BYTE_W, 8, input symbol width.
LSB_FIRST, 1, 1 = first byte lands in bits [7:0]; 0 = first byte ends in the top lane (shift-left packing).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
in_data  input  BYTE_W  input byte.
in_valid  input  1  in_data valid.
in_ready  output  1  packer can accept a byte.
flush  input  1  emit the current partial word.
word_out  output  DATA_W  packed word; unused lanes are 0.
word_valid  output  1  word_out valid.
word_ready  input  1  downstream consumes word this cycle.
byte_cnt  output  3  number of valid bytes in word_out (1..NB).

Behaviour:
- NB = DATA_W/BYTE_W, which is 4 by default. Internal cnt ranges 0..NB-1; internal buffer is DATA_W bits.
- Reset (rst=0, asynchronous):
  - state=COLLECT, cnt=0, buffer=0.
  - word_out=0, word_valid=0, byte_cnt=0.
  - in_ready=0 while rst=0.
  - A partial word held at reset is discarded without output.
- States: COLLECT, HOLD.
- in_ready = rst & (state==COLLECT), combinational from state.
- word_valid = (state==HOLD), registered.
- COLLECT state:
  - A byte is accepted on any edge with in_valid & in_ready.
  - LSB_FIRST=1: the byte is written to lane cnt.
  - LSB_FIRST=0: buffer <= {buffer[DATA_W-BYTE_W-1:0], in_data}.
  - Accept with cnt==NB-1: word_out <= the completed buffer, byte_cnt <= NB, cnt <= 0, next state HOLD.
  - Otherwise an accept sets cnt <= cnt+1.
- Latency: word_valid rises on the same edge that accepts the last byte, and is visible from the next cycle.
- flush while in COLLECT:
  - Let n = cnt + (1 if a byte is accepted in the same cycle).
  - If n>0: word_out <= buffer including that byte, byte_cnt <= n, cnt <= 0, next state HOLD.
  - If n==0: flush has no effect.
  - Flushed partial words, LSB_FIRST=1: unfilled upper lanes are 0.
  - Flushed partial words, LSB_FIRST=0: bytes are right-justified in the low n lanes; upper lanes are 0.
- HOLD state:
  - word_out and byte_cnt are held stable. No input byte is accepted. flush is ignored.
  - word_ready=1: on the edge, word_valid <= 0, buffer <= 0, state <= COLLECT.
  - word_out retains its last value until the next word is loaded.
- Throughput: minimum of NB+1 cycles per full word, one of which is the HOLD cycle.
- word_ready while in COLLECT is ignored.
- in_valid may drop at any time with no effect.
- in_data is don't-care when in_valid=0.

Test Plan:
- Reset release, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 (LSB_FIRST=1):
  - word_valid is high for exactly 1 cycle, word_out=0x44332211, byte_cnt=4.
  - in_ready=0 during that cycle.
- Same bytes with LSB_FIRST=0 -> word_out=0x11223344.
- Backpressure: word_ready=0 for 5 cycles after completion:
  - word_valid, word_out and byte_cnt stay stable; in_ready=0; in_valid bytes are not consumed.
  - After word_ready=1, the next stream packs from lane 0.
- Flush case A: bytes 0xAA,0xBB, then flush alone -> word_out=0x0000BBAA, byte_cnt=2.
- Flush case B: flush with no bytes pending -> no word_valid.
- Flush case C: flush together with the 3rd byte 0xCC -> word_out=0x00CCBBAA, byte_cnt=3.
- Reset mid-word: 2 bytes accepted, then rst pulsed low asynchronously between edges:
  - Outputs go to 0 immediately.
  - The next 4 bytes 0x01..0x04 produce word_out=0x04030201 with no stale bytes.
- Random stall soak (LSB_FIRST=1): 1000 random bytes, random in_valid/word_ready -> scoreboard matches every word in order; no byte is lost or duplicated.
